// File: rtl/cpu_defines.sv
// cpu_defines: shared fetch constants, FSM state encoding and fetch buffer entry layout.
package cpu_defines;
   localparam int INST_ADDR_W = 32;
   localparam logic [INST_ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_INST = 32'h0000_0000;
   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } fetch_state_e;
   typedef struct packed {
      logic [INST_ADDR_W-1:0] pc;
      logic [31:0]            inst;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO of {pc, inst} entries with push, pop and clear.
module fetch_fifo
   import cpu_defines::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  fetch_entry_t             din_i,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     empty_o,
   output fetch_entry_t             head_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   fetch_entry_t mem_q [DEPTH];
   logic [AW-1:0] rd_q, wr_q;
   logic [CW-1:0] count_q;
   // Depth is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
      end else if (clear_i) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + AW'(1);
         if (pop_i) rd_q <= rd_q + AW'(1);
         count_q <= count_q + CW'(push_i) - CW'(pop_i);
      end
   end
   always_ff @(posedge clk) begin
      if (push_i && !clear_i) mem_q[wr_q] <= din_i;
   end
   assign count_o = count_q;
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_q];
endmodule

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: owns the PC, sequences the combinational instruction ROM and
// buffers fetched words for decode, handling stall, flush and branch redirect.
module inst_fetch_ctrl
   import cpu_defines::*;
#(
   parameter logic [INST_ADDR_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int                     FIFO_DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall_i,
   input  logic                   flush_i,
   input  logic                   branch_flag_i,
   input  logic [INST_ADDR_W-1:0] branch_target_i,
   input  logic [INST_ADDR_W-1:0] flush_pc_i,
   output logic                   rom_ce_o,
   output logic [INST_ADDR_W-1:0] rom_addr_o,
   input  logic [31:0]            rom_inst_i,
   output logic                   id_valid_o,
   output logic [INST_ADDR_W-1:0] id_pc_o,
   output logic [31:0]            id_inst_o,
   input  logic                   id_ready_i
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [INST_ADDR_W-1:0] WORD_MASK = ~INST_ADDR_W'(3);
   fetch_state_e state_q, state_d;
   logic ce_q, ce_d;
   logic [INST_ADDR_W-1:0] pc_q, pc_d;
   logic [CW-1:0] count, post_count;
   logic empty, push, pop, clear;
   fetch_entry_t head;
   // A redirect drops whatever the ROM returns this cycle.
   assign clear      = flush_i | branch_flag_i;
   assign push       = (state_q == RUN) & ~clear;
   assign pop        = id_valid_o & id_ready_i;
   assign post_count = count + CW'(push) - CW'(pop);
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      if (flush_i) begin
         state_d = BOOT;
         pc_d    = flush_pc_i & WORD_MASK;
      end else if (branch_flag_i) begin
         state_d = RUN;
         pc_d    = branch_target_i & WORD_MASK;
      end else begin
         case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
               pc_d    = pc_q + INST_ADDR_W'(4);
               state_d = (stall_i || post_count == CW'(FIFO_DEPTH)) ? HOLD : RUN;
            end
            HOLD: state_d = (!stall_i && post_count < CW'(FIFO_DEPTH)) ? RUN : HOLD;
            default: state_d = BOOT;
         endcase
      end
      ce_d = (state_d == RUN);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= BOOT;
         ce_q    <= 1'b0;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         ce_q    <= ce_d;
         pc_q    <= pc_d;
      end
   end
   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .clear_i (clear),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   ('{pc: pc_q, inst: rom_inst_i}),
      .count_o (count),
      .empty_o (empty),
      .head_o  (head)
   );
   assign rom_ce_o   = ce_q;
   assign rom_addr_o = pc_q;
   assign id_valid_o = ~empty;
   assign id_pc_o    = empty ? '0 : head.pc;
   assign id_inst_o  = empty ? NOP_INST : head.inst;
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: directed and random stimulus; a scoreboard of expected program-order
// PCs is checked by an independent monitor on every accepted decode handshake.
module tb_inst_fetch_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic stall = 1'b0, flush = 1'b0, branch = 1'b0, ready = 1'b1;
   logic [31:0] target = '0, flush_pc = '0;
   logic ce, valid;
   logic [31:0] addr, rom_inst, id_pc, id_inst;
   logic w_ce, w_valid;
   logic [31:0] w_addr, w_rom_inst, w_pc, w_inst;
   int tests = 0, fails = 0, delivered = 0, d0;
   logic [31:0] exp_q [$];
   logic [31:0] gen_pc;

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      logic [16:0] w;
      w = a[18:2];
      case (w)
         17'd0:   return 32'h3408_0001;
         17'd1:   return 32'h3409_0002;
         17'd2:   return 32'h0128_5022;
         17'd3:   return 32'hA00A_0004;
         default: return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
      endcase
   endfunction

   assign rom_inst   = rom_word(addr);
   assign w_rom_inst = rom_word(w_addr);

   inst_fetch_ctrl dut (
      .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .branch_flag_i(branch),
      .branch_target_i(target), .flush_pc_i(flush_pc), .rom_ce_o(ce), .rom_addr_o(addr),
      .rom_inst_i(rom_inst), .id_valid_o(valid), .id_pc_o(id_pc), .id_inst_o(id_inst),
      .id_ready_i(ready)
   );

   inst_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
      .clk(clk), .rst(rst), .stall_i(1'b0), .flush_i(1'b0), .branch_flag_i(1'b0),
      .branch_target_i(32'h0), .flush_pc_i(32'h0), .rom_ce_o(w_ce), .rom_addr_o(w_addr),
      .rom_inst_i(w_rom_inst), .id_valid_o(w_valid), .id_pc_o(w_pc), .id_inst_o(w_inst),
      .id_ready_i(1'b1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fill();
      while (exp_q.size() < 8) begin
         exp_q.push_back(gen_pc);
         gen_pc = gen_pc + 32'd4;
      end
   endtask

   task automatic reset_model(input logic [31:0] base);
      exp_q.delete();
      gen_pc = base;
      fill();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      fill();
   endtask

   // Program order restarts at the redirect PC once the redirect edge has passed.
   task automatic redirect(input logic f, input logic b, input logic [31:0] fp, input logic [31:0] bt);
      flush = f;
      branch = b;
      flush_pc = fp;
      target = bt;
      @(posedge clk);
      #1;
      flush = 1'b0;
      branch = 1'b0;
      reset_model((f ? fp : bt) & ~32'h3);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (valid && ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL sb_underflow: got pc %h expected none", id_pc);
            end else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               chk("sb_pc", id_pc, e);
               chk("sb_inst", id_inst, rom_word(e));
            end
            delivered++;
         end else if (!valid) begin
            chk("idle_pc", id_pc, 32'h0);
            chk("idle_inst", id_inst, 32'h0);
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      reset_model(32'h0);
      chk("c1_ce", 32'(ce), 32'd0);
      chk("c1_valid", 32'(valid), 32'd0);
      tick();
      chk("c2_ce", 32'(ce), 32'd1);
      chk("c2_addr", addr, 32'h0);
      chk("c2_valid", 32'(valid), 32'd0);
      tick();
      chk("c3_valid", 32'(valid), 32'd1);
      chk("c3_pc", id_pc, 32'h0);
      chk("c3_inst", id_inst, 32'h3408_0001);
      chk("wrap_pc0", w_pc, 32'hFFFF_FFF8);
      tick();
      chk("c4_pc", id_pc, 32'h4);
      chk("c4_inst", id_inst, 32'h3409_0002);
      chk("wrap_pc1", w_pc, 32'hFFFF_FFFC);
      tick();
      chk("c5_pc", id_pc, 32'h8);
      chk("c5_inst", id_inst, 32'h0128_5022);
      chk("wrap_pc2", w_pc, 32'h0);
      chk("wrap_inst2", w_inst, 32'h3408_0001);
      tick();
      chk("c6_pc", id_pc, 32'hC);
      chk("c6_inst", id_inst, 32'hA00A_0004);
      tick();
      rst = 1'b1;
      #1;
      chk("arst_ce", 32'(ce), 32'd0);
      chk("arst_addr", addr, 32'h0);
      chk("arst_valid", 32'(valid), 32'd0);
      chk("arst_pc", id_pc, 32'h0);
      chk("arst_inst", id_inst, 32'h0);
      chk("arst_wrap_addr", w_addr, 32'hFFFF_FFF8);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      reset_model(32'h0);
      tick();
      tick();
      ready = 1'b0;
      chk("bp_valid", 32'(valid), 32'd1);
      tick();
      chk("bp_ce", 32'(ce), 32'd0);
      chk("bp_addr", addr, 32'h8);
      tick();
      chk("bp_ce_hold", 32'(ce), 32'd0);
      chk("bp_addr_hold", addr, 32'h8);
      chk("bp_head", id_pc, 32'h0);
      ready = 1'b1;
      repeat (6) tick();
      stall = 1'b1;
      chk("st_inflight_ce", 32'(ce), 32'd1);
      tick();
      chk("st_ce1", 32'(ce), 32'd0);
      tick();
      chk("st_ce2", 32'(ce), 32'd0);
      tick();
      stall = 1'b0;
      chk("st_ce3", 32'(ce), 32'd0);
      tick();
      chk("st_resume_ce", 32'(ce), 32'd1);
      repeat (4) tick();
      ready = 1'b0;
      repeat (3) tick();
      chk("br_full_valid", 32'(valid), 32'd1);
      chk("br_full_ce", 32'(ce), 32'd0);
      redirect(1'b0, 1'b1, 32'h0, 32'h0000_0002);
      chk("br_valid", 32'(valid), 32'd0);
      chk("br_addr", addr, 32'h0);
      chk("br_ce", 32'(ce), 32'd1);
      ready = 1'b1;
      tick();
      chk("br_deliver_valid", 32'(valid), 32'd1);
      chk("br_deliver_pc", id_pc, 32'h0);
      repeat (3) tick();
      redirect(1'b1, 1'b1, 32'h40, 32'h80);
      chk("fl_ce", 32'(ce), 32'd0);
      chk("fl_addr", addr, 32'h40);
      chk("fl_valid", 32'(valid), 32'd0);
      tick();
      chk("fl_fetch_ce", 32'(ce), 32'd1);
      chk("fl_fetch_addr", addr, 32'h40);
      tick();
      chk("fl_deliver_pc", id_pc, 32'h40);
      d0 = delivered;
      for (int i = 0; i < 2000; i++) begin
         int r;
         ready = ($urandom_range(0, 9) < 7);
         stall = ($urandom_range(0, 9) == 0);
         r = $urandom_range(0, 99);
         if (r < 2) redirect(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
         else if (r < 5) redirect(1'b0, 1'b1, 32'h0, $urandom);
         else tick();
      end
      ready = 1'b1;
      stall = 1'b0;
      repeat (5) tick();
      chk("rand_progress", 32'(delivered - d0 > 300), 32'd1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
